// File: rtl/wino_pkg.sv
// Shared definitions for the Winograd tile scheduler.
//   - scheduler state encoding
//   - stride / tile constants and dimension widths
//   - window helpers: clamped upper bound and end-of-axis test
package wino_pkg;

   localparam int DIM_W      = 9;
   localparam int OD_W       = 8;
   localparam int TILE_DIM   = 6;
   localparam int STRIDE_3X3 = 4;
   localparam int STRIDE_1X1 = 6;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_LOAD_W = 3'd1,
      ST_SWEEP  = 3'd2,
      ST_DRAIN  = 3'd3,
      ST_DONE   = 3'd4
   } state_t;

   // Inclusive window end: low + TILE_DIM - 1, clamped to dim - 1.
   // The sum is formed one bit wider so a window near 511 cannot wrap.
   function automatic logic [DIM_W-1:0] win_high(input logic [DIM_W-1:0] low,
                                                 input logic [DIM_W-1:0] dim);
      logic [DIM_W:0] top;
      top = {1'b0, low} + (DIM_W+1)'(TILE_DIM - 1);
      if (top >= {1'b0, dim})
         win_high = dim - DIM_W'(1);
      else
         win_high = top[DIM_W-1:0];
   endfunction

   // True when the window starting at low is the final one along this axis.
   function automatic logic at_end(input logic [DIM_W-1:0] low,
                                   input logic [3:0]       stride,
                                   input logic [DIM_W-1:0] dim);
      at_end = ({1'b0, low} + {{(DIM_W-3){1'b0}}, stride}) >= {1'b0, dim};
   endfunction

endpackage

// File: rtl/wino_tile_iter.sv
// Row/column tile walker for one feature-map sweep.
//   clk, reset_n     : clock, async active-low reset
//   init             : load the first window (0,0) of the current config
//   advance          : step to the next window, column fastest
//   stride           : tile stride (4 or 6)
//   dim_h, dim_w     : feature-map height / width (nonzero)
//   low_*/high_*     : registered inclusive window bounds
//   last             : registered flag, current window is the final one
// Positions are kept as pixel offsets rather than tile indices, so no
// multiply is needed: each step just adds the stride.
module wino_tile_iter
   import wino_pkg::*;
(
   input  logic             clk,
   input  logic             reset_n,
   input  logic             init,
   input  logic             advance,
   input  logic [3:0]       stride,
   input  logic [DIM_W-1:0] dim_h,
   input  logic [DIM_W-1:0] dim_w,
   output logic [DIM_W-1:0] low_h,
   output logic [DIM_W-1:0] high_h,
   output logic [DIM_W-1:0] low_w,
   output logic [DIM_W-1:0] high_w,
   output logic             last
);

   logic [DIM_W:0]   step_h;
   logic [DIM_W:0]   step_w;
   logic [DIM_W-1:0] nxt_low_h;
   logic [DIM_W-1:0] nxt_low_w;

   always_comb begin
      step_h    = {1'b0, low_h} + {{(DIM_W-3){1'b0}}, stride};
      step_w    = {1'b0, low_w} + {{(DIM_W-3){1'b0}}, stride};
      nxt_low_h = low_h;
      nxt_low_w = low_w;
      if (init) begin
         nxt_low_h = '0;
         nxt_low_w = '0;
      end else if (step_w >= {1'b0, dim_w}) begin
         // Row wrap; never requested on the last window, so step_h < dim_h.
         nxt_low_h = step_h[DIM_W-1:0];
         nxt_low_w = '0;
      end else begin
         nxt_low_w = step_w[DIM_W-1:0];
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         low_h  <= '0;
         high_h <= '0;
         low_w  <= '0;
         high_w <= '0;
         last   <= 1'b0;
      end else if (init || advance) begin
         low_h  <= nxt_low_h;
         high_h <= win_high(nxt_low_h, dim_h);
         low_w  <= nxt_low_w;
         high_w <= win_high(nxt_low_w, dim_w);
         last   <= at_end(nxt_low_h, stride, dim_h) && at_end(nxt_low_w, stride, dim_w);
      end
   end

endmodule

// File: rtl/wino_tile_scheduler.sv
// Winograd PE-chain sequencer for one convolution layer.
//   clk, reset_n          : clock, async active-low reset
//   start, cfg_*          : layer launch and configuration (latched in IDLE)
//   busy, done            : layer in progress / one-cycle end pulse
//   wt_req_*              : weight tile requests, one per PE per OD group
//   in_req_*              : input tile window requests for the current group
//   pe_tile_done          : last PE retired one tile
//
// state   | meaning
// --------+---------------------------------------------------------
// IDLE    | waiting for start
// LOAD_W  | requesting one weight tile per active PE of the group
// SWEEP   | requesting every input window, row-major
// DRAIN   | waiting for all in-flight tiles to retire
// DONE    | one-cycle done pulse, then back to IDLE
module wino_tile_scheduler
   import wino_pkg::*;
#(
   parameter int NUM_PE        = 4,
   parameter int OUTSTANDING_W = 8
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             start,
   input  logic [DIM_W-1:0] cfg_height,
   input  logic [DIM_W-1:0] cfg_width,
   input  logic [OD_W-1:0]  cfg_od,
   input  logic             cfg_weight_size,
   output logic             busy,
   output logic             done,
   output logic             wt_req_valid,
   input  logic             wt_req_ready,
   output logic [OD_W-1:0]  wt_req_od,
   output logic [3:0]       wt_req_pe,
   output logic             in_req_valid,
   input  logic             in_req_ready,
   output logic [DIM_W-1:0] in_req_low_h,
   output logic [DIM_W-1:0] in_req_high_h,
   output logic [DIM_W-1:0] in_req_low_w,
   output logic [DIM_W-1:0] in_req_high_w,
   output logic [OD_W-1:0]  in_req_od_base,
   output logic             in_req_last,
   input  logic             pe_tile_done
);

   localparam logic [OUTSTANDING_W-1:0] OUT_MAX = '1;

   state_t                   state, state_nxt;
   logic [DIM_W-1:0]         cfg_h_q, cfg_w_q;
   logic [OD_W-1:0]          cfg_od_q;
   logic                     cfg_ws_q;
   logic [OUTSTANDING_W-1:0] outst_q, outst_nxt;

   logic             busy_nxt, done_nxt;
   logic             wt_valid_nxt, in_valid_nxt;
   logic [OD_W-1:0]  wt_od_nxt, od_base_nxt;
   logic [3:0]       wt_pe_nxt;
   logic             cfg_load, it_init, it_adv;

   logic             wt_xfer, in_xfer, last_wt, more_grp, cfg_zero;
   logic [OD_W:0]    next_base;
   logic [3:0]       stride;

   assign wt_xfer   = wt_req_valid && wt_req_ready;
   assign in_xfer   = in_req_valid && in_req_ready;
   assign stride    = cfg_ws_q ? 4'(STRIDE_3X3) : 4'(STRIDE_1X1);
   assign cfg_zero  = (cfg_height == '0) || (cfg_width == '0) || (cfg_od == '0);
   assign last_wt   = (wt_req_pe == 4'(NUM_PE - 1)) ||
                      (({1'b0, wt_req_od} + (OD_W+1)'(1)) >= {1'b0, cfg_od_q});
   assign next_base = {1'b0, in_req_od_base} + (OD_W+1)'(NUM_PE);
   assign more_grp  = next_base < {1'b0, cfg_od_q};

   wino_tile_iter u_iter (
      .clk     (clk),
      .reset_n (reset_n),
      .init    (it_init),
      .advance (it_adv),
      .stride  (stride),
      .dim_h   (cfg_h_q),
      .dim_w   (cfg_w_q),
      .low_h   (in_req_low_h),
      .high_h  (in_req_high_h),
      .low_w   (in_req_low_w),
      .high_w  (in_req_high_w),
      .last    (in_req_last)
   );

   always_comb begin
      state_nxt    = state;
      busy_nxt     = busy;
      done_nxt     = 1'b0;
      wt_valid_nxt = wt_req_valid;
      wt_od_nxt    = wt_req_od;
      wt_pe_nxt    = wt_req_pe;
      in_valid_nxt = in_req_valid;
      od_base_nxt  = in_req_od_base;
      cfg_load     = 1'b0;
      it_init      = 1'b0;
      it_adv       = 1'b0;

      // A retire with nothing in flight is dropped.
      outst_nxt = outst_q;
      if (in_xfer && !(pe_tile_done && (outst_q != '0)))
         outst_nxt = outst_q + OUTSTANDING_W'(1);
      else if (!in_xfer && pe_tile_done && (outst_q != '0))
         outst_nxt = outst_q - OUTSTANDING_W'(1);

      case (state)
         ST_IDLE: begin
            if (start) begin
               cfg_load = 1'b1;
               if (cfg_zero) begin
                  state_nxt = ST_DONE;
                  done_nxt  = 1'b1;
               end else begin
                  state_nxt    = ST_LOAD_W;
                  busy_nxt     = 1'b1;
                  wt_valid_nxt = 1'b1;
                  wt_od_nxt    = '0;
                  wt_pe_nxt    = '0;
                  od_base_nxt  = '0;
               end
            end
         end
         ST_LOAD_W: begin
            if (wt_xfer) begin
               if (last_wt) begin
                  wt_valid_nxt = 1'b0;
                  state_nxt    = ST_SWEEP;
                  it_init      = 1'b1;
                  in_valid_nxt = (outst_nxt != OUT_MAX);
               end else begin
                  wt_od_nxt = wt_req_od + OD_W'(1);
                  wt_pe_nxt = wt_req_pe + 4'd1;
               end
            end
         end
         ST_SWEEP: begin
            if (in_xfer && in_req_last) begin
               in_valid_nxt = 1'b0;
               state_nxt    = ST_DRAIN;
            end else if (in_xfer || !in_req_valid) begin
               // A pending request is never withdrawn; saturation only
               // gates the next request.
               in_valid_nxt = (outst_nxt != OUT_MAX);
               it_adv       = in_xfer;
            end
         end
         ST_DRAIN: begin
            if (outst_q == '0) begin
               if (more_grp) begin
                  state_nxt    = ST_LOAD_W;
                  wt_valid_nxt = 1'b1;
                  wt_od_nxt    = next_base[OD_W-1:0];
                  wt_pe_nxt    = '0;
                  od_base_nxt  = next_base[OD_W-1:0];
               end else begin
                  state_nxt = ST_DONE;
                  busy_nxt  = 1'b0;
                  done_nxt  = 1'b1;
               end
            end
         end
         ST_DONE: begin
            state_nxt = ST_IDLE;
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state          <= ST_IDLE;
         busy           <= 1'b0;
         done           <= 1'b0;
         wt_req_valid   <= 1'b0;
         wt_req_od      <= '0;
         wt_req_pe      <= '0;
         in_req_valid   <= 1'b0;
         in_req_od_base <= '0;
         outst_q        <= '0;
         cfg_h_q        <= '0;
         cfg_w_q        <= '0;
         cfg_od_q       <= '0;
         cfg_ws_q       <= 1'b0;
      end else begin
         state          <= state_nxt;
         busy           <= busy_nxt;
         done           <= done_nxt;
         wt_req_valid   <= wt_valid_nxt;
         wt_req_od      <= wt_od_nxt;
         wt_req_pe      <= wt_pe_nxt;
         in_req_valid   <= in_valid_nxt;
         in_req_od_base <= od_base_nxt;
         outst_q        <= outst_nxt;
         if (cfg_load) begin
            cfg_h_q  <= cfg_height;
            cfg_w_q  <= cfg_width;
            cfg_od_q <= cfg_od;
            cfg_ws_q <= cfg_weight_size;
         end
      end
   end

endmodule
